// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: register port between the SPI slave (master side) and the register bank (slave side).
// Latency/backpressure: none here; read data is registered inside the bank.
interface spi_reg_bank_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] regAddr;
  logic              regWriteEn;
  logic [7:0]        regWriteData;
  logic [7:0]        regReadData;

  modport master (output regAddr, output regWriteEn, output regWriteData, input regReadData);
  modport slave  (input regAddr, input regWriteEn, input regWriteData, output regReadData);
endinterface

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: DDS shadow config with sync-aligned atomic commit and timeout fallback; active readback via SPI_REG_BANK_ACTIVE_READBACK_EN.
// Latency: read data 1 cycle after regAddr; no backpressure, one write per rising edge of regWriteEn.
module spi_reg_bank #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  ID_VALUE  = 8'hE1,
  parameter logic [31:0] FTW_RESET = 32'h0000_0000,
  parameter logic [13:0] AMP_RESET = 14'h0000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                SysClk,
  input  logic                Reset,
  spi_reg_bank_if.slave       reg_if,
  input  logic                sync_ok,
  input  logic                pll_locked,
  output logic [31:0]         dds_ftw,
  output logic [13:0]         dds_amp,
  output logic                dds_en,
  output logic                dds_update
);

  typedef struct packed {
    logic [31:0] ftw;
    logic [13:0] amp;
    logic        en;
  } dds_cfg_t;

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_APPLY} state_t;

  localparam int             CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam dds_cfg_t       CFG_RESET = '{ftw: FTW_RESET, amp: AMP_RESET, en: 1'b0};

  localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h03);
  localparam logic [ADDR_W-1:0] A_FTW0   = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_FTW1   = ADDR_W'(8'h05);
  localparam logic [ADDR_W-1:0] A_FTW2   = ADDR_W'(8'h06);
  localparam logic [ADDR_W-1:0] A_FTW3   = ADDR_W'(8'h07);
  localparam logic [ADDR_W-1:0] A_AMPL   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_AMPH   = ADDR_W'(8'h09);
`ifdef SPI_REG_BANK_ACTIVE_READBACK_EN
  localparam logic [ADDR_W-1:0] A_RFTW0  = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_RFTW1  = ADDR_W'(8'h11);
  localparam logic [ADDR_W-1:0] A_RFTW2  = ADDR_W'(8'h12);
  localparam logic [ADDR_W-1:0] A_RFTW3  = ADDR_W'(8'h13);
  localparam logic [ADDR_W-1:0] A_RAMPL  = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_RAMPH  = ADDR_W'(8'h15);
  localparam logic [ADDR_W-1:0] A_REN    = ADDR_W'(8'h16);
`endif

  dds_cfg_t         shadow;
  dds_cfg_t         active;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [7:0]       scratch;
  logic             tmo_sticky;
  logic             drop_sticky;
  logic [7:0]       rd_mux;

  logic wr;
  logic wr_ctrl;
  logic soft_rst;
  logic commit_req;
  logic w1c_tmo;
  logic w1c_drop;
  logic timeout_hit;

  assign wr          = reg_if.regWriteEn & ~we_q;
  assign wr_ctrl     = wr && (reg_if.regAddr == A_CTRL);
  assign soft_rst    = wr_ctrl && reg_if.regWriteData[2];
  assign commit_req  = wr_ctrl && reg_if.regWriteData[1] && !reg_if.regWriteData[2];
  assign w1c_tmo     = wr && (reg_if.regAddr == A_STATUS) && reg_if.regWriteData[2];
  assign w1c_drop    = wr && (reg_if.regAddr == A_STATUS) && reg_if.regWriteData[3];
  assign timeout_hit = (state == ST_PENDING) && !sync_ok && (cnt == CNT_LAST);

  assign dds_ftw = active.ftw;
  assign dds_amp = active.amp;
  assign dds_en  = active.en;

  // Edge detector survives SOFT_RST so a held write level cannot re-trigger.
  always_ff @(posedge SysClk) begin
    if (Reset) we_q <= 1'b0;
    else       we_q <= reg_if.regWriteEn;
  end

  always_ff @(posedge SysClk) begin
    if (Reset)                                     scratch <= 8'h00;
    else if (wr && (reg_if.regAddr == A_SCRATCH))  scratch <= reg_if.regWriteData;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (reg_if.regAddr)
      A_ID:      rd_mux = ID_VALUE;
      A_SCRATCH: rd_mux = scratch;
      A_CTRL:    rd_mux = {7'b0, shadow.en};
      A_STATUS:  rd_mux = {4'b0, drop_sticky, tmo_sticky, (state != ST_IDLE), pll_locked};
      A_FTW0:    rd_mux = shadow.ftw[7:0];
      A_FTW1:    rd_mux = shadow.ftw[15:8];
      A_FTW2:    rd_mux = shadow.ftw[23:16];
      A_FTW3:    rd_mux = shadow.ftw[31:24];
      A_AMPL:    rd_mux = shadow.amp[7:0];
      A_AMPH:    rd_mux = {2'b0, shadow.amp[13:8]};
`ifdef SPI_REG_BANK_ACTIVE_READBACK_EN
      A_RFTW0:   rd_mux = active.ftw[7:0];
      A_RFTW1:   rd_mux = active.ftw[15:8];
      A_RFTW2:   rd_mux = active.ftw[23:16];
      A_RFTW3:   rd_mux = active.ftw[31:24];
      A_RAMPL:   rd_mux = active.amp[7:0];
      A_RAMPH:   rd_mux = {2'b0, active.amp[13:8]};
      A_REN:     rd_mux = {7'b0, active.en};
`endif
      default:   rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (Reset || soft_rst) begin
      shadow             <= CFG_RESET;
      active             <= CFG_RESET;
      state              <= ST_IDLE;
      cnt                <= '0;
      tmo_sticky         <= 1'b0;
      drop_sticky        <= 1'b0;
      dds_update         <= 1'b0;
      reg_if.regReadData <= 8'h00;
    end else begin
      dds_update         <= 1'b0;
      reg_if.regReadData <= rd_mux;

      if (wr) begin
        case (reg_if.regAddr)
          A_CTRL:  shadow.en         <= reg_if.regWriteData[0];
          A_FTW0:  shadow.ftw[7:0]   <= reg_if.regWriteData;
          A_FTW1:  shadow.ftw[15:8]  <= reg_if.regWriteData;
          A_FTW2:  shadow.ftw[23:16] <= reg_if.regWriteData;
          A_FTW3:  shadow.ftw[31:24] <= reg_if.regWriteData;
          A_AMPL:  shadow.amp[7:0]   <= reg_if.regWriteData;
          A_AMPH:  shadow.amp[13:8]  <= reg_if.regWriteData[5:0];
          default: ;
        endcase
      end

      if (timeout_hit)  tmo_sticky <= 1'b1;
      else if (w1c_tmo) tmo_sticky <= 1'b0;

      if (commit_req && (state != ST_IDLE)) drop_sticky <= 1'b1;
      else if (w1c_drop)                    drop_sticky <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (commit_req) begin
            state <= ST_PENDING;
            cnt   <= '0;
          end
        end
        ST_PENDING: begin
          cnt <= cnt + CNT_W'(1);
          if (sync_ok || (cnt == CNT_LAST)) state <= ST_APPLY;
        end
        ST_APPLY: begin
          // Nonblocking capture: a shadow write on this edge lands after the copy.
          active     <= shadow;
          dds_update <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Register bank directly downstream of the SPI slave interface; consumes its register port (regAddr/regWriteEn/regWriteData) and returns regReadData.
- Holds shadow DDS configuration (frequency tuning word, amplitude, enable) and transfers it atomically to active outputs on a commit command.
- The commit is aligned to a DDS sync strobe, with a timeout fallback.
- Runs entirely in the 300 MHz SysClk domain; regWriteEn arrives as a level that may stay high for several cycles.

Parameters:
- ADDR_W, 8, register address width
- ID_VALUE, 8'hE1, constant returned at address 0x00
- FTW_RESET, 32'h0000_0000, reset value of shadow and active FTW
- AMP_RESET, 14'h0000, reset value of shadow and active amplitude
- TIMEOUT, 1024, SysClk cycles a pending commit waits for sync_ok before forcing apply (>=2)

Ports:
- SysClk  in  1  system clock, all logic rising-edge
- Reset  in  1  synchronous, active-high
- regAddr  in  ADDR_W  register address from SPI interface
- regWriteEn  in  1  write request level; acted on at rising edge only
- regWriteData  in  8  write data
- regReadData  out  8  registered read data
- sync_ok  in  1  DDS safe-update strobe (phase boundary)
- pll_locked  in  1  live clock-wizard lock status
- dds_ftw  out  32  active frequency tuning word
- dds_amp  out  14  active amplitude
- dds_en  out  1  active DDS enable
- dds_update  out  1  one-cycle pulse on each apply

Behaviour:
- Reset values: regReadData=0, dds_ftw=FTW_RESET, dds_amp=AMP_RESET, dds_en=0, dds_update=0. All shadows take the same defaults. SCRATCH=0, sticky bits=0, FSM=IDLE, timeout counter=0.
- Write detect: we_q registers regWriteEn. A write is performed only in the cycle where regWriteEn=1 and we_q=0. Holding the level high produces exactly one write.
- Register map (byte-wide):
  - 0x00 ID: RO, ID_VALUE.
  - 0x01 SCRATCH: RW.
  - 0x02 CTRL:
    - bit0 en_shadow RW.
    - bit1 COMMIT: write 1 only; always reads 0.
    - bit2 SOFT_RST: write 1 only; always reads 0.
  - 0x03 STATUS:
    - bit0 pll_locked (live).
    - bit1 commit_pending.
    - bit2 TIMEOUT_STICKY: W1C.
    - bit3 COMMIT_DROPPED sticky: W1C.
  - 0x04..0x07: FTW shadow bytes 0..3, LSB first.
  - 0x08: AMP shadow [7:0].
  - 0x09: AMP shadow [13:8] in bits 5:0; upper bits write-ignored, read 0.
  - Unmapped addresses read 0x00; writes to them are ignored.
- Read: regReadData <= mux(regAddr) every cycle, giving 1-cycle latency. STATUS reflects register state as of the previous edge.
- Commit FSM:
  - IDLE: a COMMIT write moves to PENDING and clears the counter.
  - PENDING: the counter increments each cycle. If sync_ok=1, go to APPLY. Else, if counter==TIMEOUT-1, set TIMEOUT_STICKY and go to APPLY.
  - APPLY (one cycle): active <= shadow (ftw, amp, en_shadow); dds_update=1; return to IDLE.
- Boundary rules:
  - COMMIT written while in PENDING or APPLY is dropped: sets COMMIT_DROPPED and does not restart the counter.
  - sync_ok on the same cycle as the COMMIT write is not used; sync_ok is sampled from the first PENDING cycle onward.
  - A shadow write in the APPLY cycle: active takes the pre-write shadow value, and the shadow takes the new value.
  - A CTRL write with COMMIT=1 and a new en_shadow updates en_shadow first; the commit carries the new value.
  - SOFT_RST=1: next cycle, everything returns to reset values except SCRATCH. Any in-flight commit is abandoned with no dds_update. SOFT_RST takes priority over COMMIT in the same write.
  - Reset mid-PENDING: FSM returns to IDLE with no dds_update.
  - W1C and a sticky set in the same cycle: the set wins.

Optional Feature:
- Macro: SPI_REG_BANK_ACTIVE_READBACK_EN.
- Defined: addresses 0x10..0x13 read active dds_ftw bytes (LSB first), 0x14/0x15 read active dds_amp in the same layout as 0x08/0x09, and 0x16 bit0 reads dds_en. All are RO.
- Undefined: 0x10..0x16 are unmapped and read 0x00.

Test Plan:
- Reset, then read 0x00 and 0x01 -> regReadData 0xE1 then 0x00, each one cycle after regAddr is presented. All DDS outputs are at reset values.
- Write 0x5A to 0x01 with regWriteEn held high for 5 cycles -> exactly one write. Read 0x01 = 0x5A; SCRATCH is retained after a SOFT_RST write of 0x04 to 0x02.
- Write FTW bytes 0x78,0x56,0x34,0x12, AMP 0xFF/0x3F, CTRL=0x03, then sync_ok pulse 10 cycles later -> dds_ftw=0x12345678, dds_amp=0x3FFF, dds_en=1 with a single dds_update pulse. No output changes before sync_ok.
- COMMIT with sync_ok held low, TIMEOUT=16 -> apply occurs exactly 16 cycles after entering PENDING. STATUS reads 0x05 (pll_locked=1). Writing 0x04 to 0x03 clears it to 0x01.
- Second COMMIT issued during PENDING -> only one dds_update and STATUS bit3 set. SOFT_RST during PENDING -> no dds_update and outputs return to defaults.
- With SPI_REG_BANK_ACTIVE_READBACK_EN defined, after the commit above read 0x13 -> 0x12. Without the macro, the same read -> 0x00.
